// File: rtl/ox_pkg.sv
// -----------------------------------------------------------------------------
// ox_pkg
// Shared definitions for the OX2M transmit arbiter:
//   - default qqwd width, FIFO depth and per-packet word limit
//   - one-hot FSM state encodings
//   - FIFO entry field offsets (the flags sit just above the data field)
// No ports; imported by ox_tx_arb and ox_sync_fifo users.
// -----------------------------------------------------------------------------
package ox_pkg;

    localparam int OX_QQWD_W       = 256;
    localparam int OX_FIFO_DEPTH   = 16;
    localparam int OX_MAX_PKT_QQWD = 8;

    // FIFO entry = {sop, eop, data}; offsets are relative to the data width,
    // so the sop flag lives at bit QQWD_W+SOP_BIT.
    localparam int EOP_BIT = 0;
    localparam int SOP_BIT = 1;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_GNT_RST = 4'b0010,
        ST_GNT_TX  = 4'b0100,
        ST_FLUSH   = 4'b1000
    } ox_state_e;

endpackage

// File: rtl/ox_sync_fifo.sv
// -----------------------------------------------------------------------------
// ox_sync_fifo
// Single-clock first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst_      clock, async active-low reset (empties the FIFO)
//   i_push         write request; ignored when full (caller flags the drop)
//   i_push_data    entry to write
//   i_pop          read request; ignored when empty
//   o_head         head entry, forced to zero while empty
//   o_valid        FIFO not empty
//   o_full         FIFO full
//   o_count        number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module ox_sync_fifo #(
    parameter int W     = 258,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_valid   = (r_count != {(AW+1){1'b0}});
    assign o_full    = (r_count == FULL_CNT);
    assign o_count   = r_count;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && o_valid;
    assign o_head    = o_valid ? r_mem[r_rd_ptr] : {W{1'b0}};

    // Pointer and occupancy tracking; push+pop together leaves the count alone
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, head is gated by valid
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/ox_tx_arb.sv
// -----------------------------------------------------------------------------
// ox_tx_arb
// Arbitrates between the reset/credit-init controller and the normal TX path,
// frames the granted source's qqwds with sop/eop and buffers them for the MAC.
// Ports:
//   clk, rst_                    clock, async active-low reset
//   rst2ox_rst_ctrl_req          reset-ctrl request (fixed priority)
//   ox2rst_rst_ctrl_grant        reset-ctrl grant, held for the whole packet
//   rst2ox_send_pkt_data/_credit_we/_pkt_done   reset-ctrl word stream
//   tx2ox_req / ox2tx_grant      TX-path request / grant
//   tx2ox_data/_we/_done         TX-path word stream
//   ox2mac_tx_data/_valid/_sop/_eop, mac2ox_tx_ready   MAC valid/ready side
//   ox_pkt_cnt                   packets committed (eop written), wrapping
//   ox_ovf_err                   sticky: oversize packet or push-when-full
// -----------------------------------------------------------------------------
module ox_tx_arb
    import ox_pkg::*;
#(
    parameter int QQWD_W       = OX_QQWD_W,
    parameter int FIFO_DEPTH   = OX_FIFO_DEPTH,
    parameter int MAX_PKT_QQWD = OX_MAX_PKT_QQWD
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              rst2ox_rst_ctrl_req,
    output logic              ox2rst_rst_ctrl_grant,
    input  logic [QQWD_W-1:0] rst2ox_send_pkt_data,
    input  logic              rst2ox_pkt_credit_we,
    input  logic              rst2ox_pkt_done,
    input  logic              tx2ox_req,
    output logic              ox2tx_grant,
    input  logic [QQWD_W-1:0] tx2ox_data,
    input  logic              tx2ox_we,
    input  logic              tx2ox_done,
    output logic [QQWD_W-1:0] ox2mac_tx_data,
    output logic              ox2mac_tx_valid,
    output logic              ox2mac_tx_sop,
    output logic              ox2mac_tx_eop,
    input  logic              mac2ox_tx_ready,
    output logic [15:0]       ox_pkt_cnt,
    output logic              ox_ovf_err
);

    localparam int ENTRY_W = QQWD_W + 2;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int WC_W    = $clog2(MAX_PKT_QQWD + 1);
    // A grant is only given when a maximum-size packet is guaranteed to fit
    localparam logic [CNT_W-1:0] FREE_LIMIT = CNT_W'(FIFO_DEPTH - MAX_PKT_QQWD);
    localparam logic [WC_W-1:0]  WC_MAX     = WC_W'(MAX_PKT_QQWD);

    ox_state_e           r_state;
    ox_state_e           w_state_nxt;
    logic                r_src_rst;
    logic                r_rst_grant;
    logic                r_tx_grant;
    logic                w_rst_grant_nxt;
    logic                w_tx_grant_nxt;

    logic                w_we;
    logic                w_done;
    logic [QQWD_W-1:0]   w_data;
    logic                w_acc;
    logic                w_drop;

    logic [QQWD_W-1:0]   r_stg_data;
    logic                r_stg_sop;
    logic                r_stg_vld;
    logic [WC_W-1:0]     r_wcnt;

    logic                w_push;
    logic                w_push_eop;
    logic [ENTRY_W-1:0]  w_push_entry;
    logic [ENTRY_W-1:0]  w_fifo_head;
    logic                w_fifo_valid;
    logic                w_fifo_full;
    logic [CNT_W-1:0]    w_fifo_cnt;
    logic                w_free_ok;

    logic [15:0]         r_pkt_cnt;
    logic                r_ovf_err;

    assign w_free_ok = (w_fifo_cnt <= FREE_LIMIT);
    // Words past the per-packet limit are dropped; the staged word then keeps
    // the eop so the packet still closes on its last accepted word.
    assign w_acc  = w_we && (r_wcnt < WC_MAX);
    assign w_drop = w_we && !(r_wcnt < WC_MAX);

    // FSM state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; arbitration happens only in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rst2ox_rst_ctrl_req && w_free_ok) begin
                    w_state_nxt = ST_GNT_RST;
                end else if (tx2ox_req && w_free_ok) begin
                    w_state_nxt = ST_GNT_TX;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT_RST, ST_GNT_TX: begin
                if (w_done && w_acc) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode for the state being entered, so the grants are flops
    always_comb begin
        w_rst_grant_nxt = 1'b0;
        w_tx_grant_nxt  = 1'b0;
        case (w_state_nxt)
            ST_GNT_RST: w_rst_grant_nxt = 1'b1;
            ST_GNT_TX:  w_tx_grant_nxt  = 1'b1;
            ST_FLUSH: begin
                w_rst_grant_nxt = r_src_rst;
                w_tx_grant_nxt  = !r_src_rst;
            end
            default: begin
                w_rst_grant_nxt = 1'b0;
                w_tx_grant_nxt  = 1'b0;
            end
        endcase
    end

    // Grant registers and owner of the current packet (needed during FLUSH)
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rst_grant <= 1'b0;
            r_tx_grant  <= 1'b0;
            r_src_rst   <= 1'b0;
        end else begin
            r_rst_grant <= w_rst_grant_nxt;
            r_tx_grant  <= w_tx_grant_nxt;
            if (r_state == ST_IDLE) begin
                r_src_rst <= (w_state_nxt == ST_GNT_RST);
            end
        end
    end

    // Source mux: only the granted source's stream is looked at
    always_comb begin
        w_we   = 1'b0;
        w_done = 1'b0;
        w_data = {QQWD_W{1'b0}};
        case (r_state)
            ST_GNT_RST: begin
                w_we   = rst2ox_pkt_credit_we;
                w_done = rst2ox_pkt_done;
                w_data = rst2ox_send_pkt_data;
            end
            ST_GNT_TX: begin
                w_we   = tx2ox_we;
                w_done = tx2ox_done;
                w_data = tx2ox_data;
            end
            default: begin
                w_we   = 1'b0;
                w_done = 1'b0;
                w_data = {QQWD_W{1'b0}};
            end
        endcase
    end

    // FIFO write select: the staged word leaves when displaced, on done, or in FLUSH
    always_comb begin
        w_push     = 1'b0;
        w_push_eop = 1'b0;
        if (r_state == ST_FLUSH) begin
            w_push     = r_stg_vld;
            w_push_eop = 1'b1;
        end else if (w_acc) begin
            w_push     = r_stg_vld;
            w_push_eop = 1'b0;
        end else if (w_done) begin
            w_push     = r_stg_vld;
            w_push_eop = 1'b1;
        end else begin
            w_push     = 1'b0;
            w_push_eop = 1'b0;
        end
    end

    assign w_push_entry = {r_stg_sop, w_push_eop, r_stg_data};

    // Staging register, packet word counter, committed-packet count, error flag
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_stg_data <= {QQWD_W{1'b0}};
            r_stg_sop  <= 1'b0;
            r_stg_vld  <= 1'b0;
            r_wcnt     <= {WC_W{1'b0}};
            r_pkt_cnt  <= 16'd0;
            r_ovf_err  <= 1'b0;
        end else begin
            // In FLUSH the staged word is the pending-eop word; it leaves this cycle
            if ((r_state == ST_IDLE) || (r_state == ST_FLUSH) || (w_done && !w_acc)) begin
                r_stg_vld <= 1'b0;
                r_stg_sop <= 1'b0;
                r_wcnt    <= {WC_W{1'b0}};
            end else if (w_acc) begin
                r_stg_data <= w_data;
                r_stg_sop  <= (r_wcnt == {WC_W{1'b0}});
                r_stg_vld  <= 1'b1;
                r_wcnt     <= r_wcnt + WC_W'(1);
            end
            if (w_push && w_push_eop && !w_fifo_full) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_drop || (w_push && w_fifo_full)) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    ox_sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_        (rst_),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_fifo_valid && mac2ox_tx_ready),
        .o_head      (w_fifo_head),
        .o_valid     (w_fifo_valid),
        .o_full      (w_fifo_full),
        .o_count     (w_fifo_cnt)
    );

    assign ox2rst_rst_ctrl_grant = r_rst_grant;
    assign ox2tx_grant           = r_tx_grant;
    assign ox2mac_tx_data        = w_fifo_head[QQWD_W-1:0];
    assign ox2mac_tx_sop         = w_fifo_head[QQWD_W+SOP_BIT];
    assign ox2mac_tx_eop         = w_fifo_head[QQWD_W+EOP_BIT];
    assign ox2mac_tx_valid       = w_fifo_valid;
    assign ox_pkt_cnt            = r_pkt_cnt;
    assign ox_ovf_err            = r_ovf_err;

endmodule
